time_match_bank: RTL and testbench

- Registered, multi-channel successor to the single 19-bit equality comparator used in the stopwatch datapath.
- Holds CHANNELS programmable target values, e.g. alarm or lap thresholds.
- Compares each target against the running stopwatch count whenever a new count is presented.
- Produces edge-qualified match pulses, sticky match flags, and a priority-encoded first-match index.
- Sits between the BCD/binary time counter and the alarm/display control logic.

---
 rtl/time_match_bank_if.sv | 32 +++
 rtl/time_match_bank.sv | 80 ++++++++
 tb/tb_time_match_bank.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/time_match_bank_if.sv
// Bus bundle for the multi-channel time match bank.
// Control/target inputs from the host side, match status back to it.
interface time_match_bank_if #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [WIDTH-1:0]    count_in;
    logic                count_valid;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [WIDTH-1:0]    wr_data;
    logic                wr_mode;
    logic [CHANNELS-1:0] ch_enable;
    logic                clr_flags;
    logic [CHANNELS-1:0] match_pulse;
    logic [CHANNELS-1:0] match_flag;
    logic                any_match;
    logic [SEL_W-1:0]    first_ch;

    modport master (
        output count_in, count_valid, wr_en, wr_sel, wr_data,
        output wr_mode, ch_enable, clr_flags,
        input  match_pulse, match_flag, any_match, first_ch
    );

    modport slave (
        input  count_in, count_valid, wr_en, wr_sel, wr_data,
        input  wr_mode, ch_enable, clr_flags,
        output match_pulse, match_flag, any_match, first_ch
    );
endinterface

// File: rtl/time_match_bank.sv
// Programmable multi-channel compare bank for the stopwatch count.
// Edge-qualified pulses, sticky flags and lowest-index match encoder.
module time_match_bank #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input logic clk,
    input logic rst,
    time_match_bank_if.slave bus
);
    logic [WIDTH-1:0]    target_q [CHANNELS];
    logic [WIDTH-1:0]    target_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] flag_q, flag_d;
    logic [CHANNELS-1:0] cond;
    logic                any_q;
    logic [SEL_W-1:0]    first_q, first_d;
    logic                wr_hit;

    assign wr_hit = bus.wr_en && (32'(bus.wr_sel) < 32'(CHANNELS));

    always_comb begin
        target_d = target_q;
        mode_d   = mode_q;
        prev_d   = prev_q;
        cond     = '0;
        pulse_d  = '0;
        first_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cond[i] = bus.ch_enable[i] &&
                      (mode_q[i] ? (bus.count_in >= target_q[i])
                                 : (bus.count_in == target_q[i]));
            pulse_d[i] = bus.count_valid && cond[i] && !prev_q[i];
            // A fresh target re-arms its channel; disabling forces re-arm too.
            if (!bus.ch_enable[i]) begin
                prev_d[i] = 1'b0;
            end else if (wr_hit && int'(bus.wr_sel) == i) begin
                prev_d[i] = 1'b0;
            end else if (bus.count_valid) begin
                prev_d[i] = cond[i];
            end
            if (wr_hit && int'(bus.wr_sel) == i) begin
                target_d[i] = bus.wr_data;
                mode_d[i]   = bus.wr_mode;
            end
        end
        flag_d = (flag_q & ~{CHANNELS{bus.clr_flags}}) | pulse_d;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (flag_d[i]) first_d = SEL_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) target_q[i] <= '0;
            mode_q  <= '0;
            prev_q  <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            any_q   <= 1'b0;
            first_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) target_q[i] <= target_d[i];
            mode_q  <= mode_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            any_q   <= |flag_d;
            first_q <= first_d;
        end
    end

    assign bus.match_pulse = pulse_q;
    assign bus.match_flag  = flag_q;
    assign bus.any_match   = any_q;
    assign bus.first_ch    = first_q;
endmodule

// File: tb/tb_time_match_bank.sv
// Self-checking bench for time_match_bank: vector table, directed
// corner sequences and random traffic against a rule-level model.
module tb_time_match_bank;
    localparam int W  = 19;
    localparam int CH = 4;
    localparam int SW = 2;
    localparam logic [W-1:0] TOP = {W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    time_match_bank_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) ifa ();
    time_match_bank_if #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) ifb ();

    time_match_bank #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    time_match_bank #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference state: what the spec says each channel remembers.
    logic [W-1:0]  m_tgt [CH];
    logic [CH-1:0] m_mode, m_armed_off, m_flag, m_pulse;

    task automatic model(input logic r, input logic cv, input logic [W-1:0] cnt,
                         input logic [CH-1:0] en, input logic clr, input logic we,
                         input int sel, input logic [W-1:0] data, input logic md);
        logic hit;
        if (r) begin
            for (int i = 0; i < CH; i++) m_tgt[i] = '0;
            m_mode = '0; m_armed_off = '0; m_flag = '0; m_pulse = '0;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            if (m_mode[i]) hit = cv && en[i] && (cnt >= m_tgt[i]);
            else           hit = cv && en[i] && (cnt == m_tgt[i]);
            m_pulse[i] = hit && !m_armed_off[i];
            if (cv) m_armed_off[i] = hit;
            if (!en[i]) m_armed_off[i] = 1'b0;
            if (we && sel < CH && sel == i) begin
                m_armed_off[i] = 1'b0;
                m_tgt[i] = data;
                m_mode[i] = md;
            end
        end
        m_flag = (clr ? '0 : m_flag) | m_pulse;
    endtask

    function automatic logic [SW-1:0] lowest(input logic [CH-1:0] f);
        for (int i = 0; i < CH; i++) if (f[i]) return SW'(i);
        return '0;
    endfunction

    task automatic cyc(input logic cv, input logic [W-1:0] cnt,
                       input logic [CH-1:0] en, input logic clr = 1'b0,
                       input logic we = 1'b0, input int sel = 0,
                       input logic [W-1:0] data = '0, input logic md = 1'b0,
                       input logic r = 1'b0);
        rst = r;
        ifa.count_valid = cv; ifa.count_in = cnt; ifa.ch_enable = en;
        ifa.clr_flags = clr; ifa.wr_en = we; ifa.wr_sel = SW'(sel);
        ifa.wr_data = data; ifa.wr_mode = md;
        model(r, cv, cnt, en, clr, we, sel, data, md);
        @(posedge clk);
        #1;
        chk("pulse", 32'(ifa.match_pulse), 32'(m_pulse));
        chk("flag", 32'(ifa.match_flag), 32'(m_flag));
        chk("any", 32'(ifa.any_match), 32'(|m_flag));
        chk("first", 32'(ifa.first_ch), 32'(lowest(m_flag)));
    endtask

    task automatic wr(input int sel, input logic [W-1:0] data, input logic md,
                      input logic [CH-1:0] en);
        cyc(1'b0, '0, en, 1'b0, 1'b1, sel, data, md);
    endtask

    task automatic bcyc(input logic cv, input logic [W-1:0] cnt, input logic we,
                        input logic [1:0] sel, input logic [W-1:0] data,
                        input logic md);
        ifb.count_valid = cv; ifb.count_in = cnt; ifb.wr_en = we;
        ifb.wr_sel = sel; ifb.wr_data = data; ifb.wr_mode = md;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0]  cnt;
        logic [CH-1:0] pulse;
        logic [CH-1:0] flag;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int n;
        logic [CH-1:0] en;
        tbl[0] = '{12343, 4'b0000, 4'b0000};
        tbl[1] = '{12344, 4'b0000, 4'b0000};
        tbl[2] = '{12345, 4'b0001, 4'b0001};
        tbl[3] = '{12346, 4'b0000, 4'b0001};
        tbl[4] = '{12347, 4'b0000, 4'b0001};
        ifb.count_valid = 0; ifb.count_in = '0; ifb.wr_en = 0; ifb.wr_sel = '0;
        ifb.wr_data = '0; ifb.wr_mode = 0; ifb.ch_enable = '0; ifb.clr_flags = 0;

        cyc(0, '0, '0, 0, 0, 0, '0, 0, 1'b1);
        cyc(1, '0, 4'b0001);
        chk("pre_rst_flag", 32'(ifa.match_flag), 32'h1);
        cyc(0, '0, 4'b0001, 0, 0, 0, '0, 0, 1'b1);
        cyc(0, '0, 4'b0001, 0, 0, 0, '0, 0, 1'b1);
        chk("rst_flag", 32'(ifa.match_flag), 0);
        chk("rst_any", 32'(ifa.any_match), 0);
        cyc(1, '0, 4'b0000);
        chk("dis_nopulse", 32'(ifa.match_pulse), 0);

        wr(0, 12345, 0, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            cyc(1, tbl[k].cnt, 4'b0001);
            chk("eq_pulse", 32'(ifa.match_pulse), 32'(tbl[k].pulse));
            chk("eq_flag", 32'(ifa.match_flag), 32'(tbl[k].flag));
        end
        chk("eq_any", 32'(ifa.any_match), 1);
        chk("eq_first", 32'(ifa.first_ch), 0);

        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1, 12345, 4'b0001);
            n += int'(ifa.match_pulse[0]);
        end
        chk("hold_pulses", n, 1);
        for (int k = 0; k < 5; k++) cyc(0, 12345, 4'b0001);
        cyc(1, 12345, 4'b0001);
        chk("resume_nopulse", 32'(ifa.match_pulse[0]), 0);

        wr(2, 524280, 1, 4'b0101);
        for (int c = 524278; c <= 524287; c++) begin
            cyc(1, W'(c), 4'b0101);
            chk("ge_pulse", 32'(ifa.match_pulse[2]), 32'(c == 524280));
        end
        cyc(1, '0, 4'b0101);
        chk("wrap_pulse", 32'(ifa.match_pulse[2]), 0);
        cyc(1, 524281, 4'b0101);
        chk("relap_pulse", 32'(ifa.match_pulse[2]), 1);

        cyc(0, '0, '0, 0, 0, 0, '0, 0, 1'b1);
        wr(1, 500, 0, 4'b1010);
        wr(3, 500, 0, 4'b1010);
        cyc(1, 500, 4'b1010);
        chk("prio_pulse", 32'(ifa.match_pulse), 32'hA);
        chk("prio_first", 32'(ifa.first_ch), 1);
        cyc(1, 501, 4'b1010);
        cyc(1, 500, 4'b1000, 1'b1);
        chk("clrset_flag", 32'(ifa.match_flag), 32'h8);
        chk("clrset_first", 32'(ifa.first_ch), 3);
        cyc(1, 501, 4'b0000);
        cyc(1, 500, 4'b0000);
        chk("dis_keep_flag", 32'(ifa.match_flag), 32'h8);
        chk("dis_nopulse2", 32'(ifa.match_pulse), 0);

        cyc(0, '0, '0, 0, 0, 0, '0, 0, 1'b1);
        cyc(1, 700, 4'b0001, 0, 1, 0, 700, 0);
        chk("coll_old", 32'(ifa.match_pulse), 0);
        cyc(1, 700, 4'b0001);
        chk("coll_new", 32'(ifa.match_pulse), 1);
        cyc(1, 800, 4'b0001, 0, 1, 0, 750, 1);
        cyc(1, 800, 4'b0001);
        chk("ge_rewrite", 32'(ifa.match_pulse), 1);

        en = 4'b1111;
        for (int k = 0; k < 3000; k++) begin
            logic [W-1:0] c, d;
            c = ($urandom_range(0, 7) == 0) ? TOP - W'($urandom_range(0, 3))
                                            : W'($urandom_range(0, 15));
            d = ($urandom_range(0, 7) == 0) ? TOP - W'($urandom_range(0, 3))
                                            : W'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) en = CH'($urandom);
            cyc($urandom_range(0, 3) != 0, c, en, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), d,
                1'($urandom), $urandom_range(0, 299) == 0);
        end

        rst = 1'b1;
        bcyc(0, '0, 0, 0, '0, 0);
        rst = 1'b0;
        ifb.ch_enable = 3'b111;
        bcyc(0, '0, 1, 0, 10, 0);
        bcyc(0, '0, 1, 1, 20, 0);
        bcyc(0, '0, 1, 2, 30, 0);
        bcyc(0, '0, 1, 3, 10, 1);
        bcyc(1, 10, 0, 0, '0, 0);
        chk("b_ch0", 32'(ifb.match_pulse), 32'h1);
        bcyc(1, 20, 0, 0, '0, 0);
        chk("b_ch1", 32'(ifb.match_pulse), 32'h2);
        bcyc(1, 30, 0, 0, '0, 0);
        chk("b_ch2", 32'(ifb.match_pulse), 32'h4);
        bcyc(1, 40, 0, 0, '0, 0);
        chk("b_none", 32'(ifb.match_pulse), 0);
        chk("b_flag", 32'(ifb.match_flag), 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
